// File: rtl/cu_multicycle.sv
// rtl/cu_multicycle.sv - multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing, req/ack memory port, stack pointer
// Optional interrupt entry (irq/irq_ack ports, IRQ state) is enabled by defining CU_IRQ_EN.
module cu_multicycle #(
   parameter int OPW         = 6,
   parameter int IMMW        = 9,
   parameter int NREG        = 2,
   parameter int STACK_DEPTH = 8
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [OPW-1:0]                     opcode,
   input  logic [$clog2(NREG)-1:0]            ra,
   input  logic [$clog2(NREG+2)-1:0]          ra_stack,
   input  logic [IMMW-1:0]                    imm,
   input  logic [3:0]                         flags,
   input  logic                               mem_ack,
`ifdef CU_IRQ_EN
   input  logic                               irq,
   output logic                               irq_ack,
`endif
   output logic                               mem_req,
   output logic                               mem_we,
   output logic                               ir_load,
   output logic                               pc_inc,
   output logic                               pc_load,
   output logic                               tr,
   output logic                               mov,
   output logic                               alu_en,
   output logic                               flag_we,
   output logic                               acc_we,
   output logic [NREG-1:0]                    reg_we,
   output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
   output logic                               halted,
   output logic                               illegal,
   output logic                               stack_fault
);

   localparam int SPW = $clog2(STACK_DEPTH+1);

   localparam logic [OPW-1:0] OP_TRX = OPW'(6'b000000);
   localparam logic [OPW-1:0] OP_TRY = OPW'(6'b000001);
   localparam logic [OPW-1:0] OP_LD  = OPW'(6'b000010);
   localparam logic [OPW-1:0] OP_ST  = OPW'(6'b000011);
   localparam logic [OPW-1:0] OP_PSH = OPW'(6'b000100);
   localparam logic [OPW-1:0] OP_POP = OPW'(6'b000101);
   localparam logic [OPW-1:0] OP_BRZ = OPW'(6'b000110);
   localparam logic [OPW-1:0] OP_BRN = OPW'(6'b000111);
   localparam logic [OPW-1:0] OP_BRC = OPW'(6'b001000);
   localparam logic [OPW-1:0] OP_BRV = OPW'(6'b001001);
   localparam logic [OPW-1:0] OP_BRA = OPW'(6'b001010);
   localparam logic [OPW-1:0] OP_CMP = OPW'(6'b010100);
   localparam logic [OPW-1:0] OP_AL0 = OPW'(6'b010101);
   localparam logic [OPW-1:0] OP_AL1 = OPW'(6'b010110);
   localparam logic [OPW-1:0] OP_MOV = OPW'(6'b010111);
   localparam logic [OPW-1:0] OP_HLT = OPW'(6'b111111);

   localparam logic [NREG-1:0] REG_ONE = {{(NREG-1){1'b0}}, 1'b1};
   localparam logic [SPW-1:0]  SP_FULL = SPW'(STACK_DEPTH);
   localparam logic [SPW-1:0]  SP_ONE  = SPW'(1);

   // S_IRLD is the fetch-completion cycle in which the instruction register loads
   typedef enum logic [2:0] {
      S_FETCH,
      S_IRLD,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
`ifdef CU_IRQ_EN
      S_IRQ,
`endif
      S_HALT
   } state_t;

   state_t          state, state_d;
   logic [SPW-1:0]  sp_d;
   logic            mem_req_d, mem_we_d, ir_load_d, pc_inc_d, pc_load_d;
   logic            tr_d, mov_d, alu_en_d, flag_we_d, acc_we_d;
   logic [NREG-1:0] reg_we_d;
   logic            halted_d, illegal_d, stack_fault_d;
   logic            op_legal;
`ifdef CU_IRQ_EN
   logic            irq_ack_d;
`endif

   always_comb begin
      op_legal = 1'b0;
      case (opcode)
         OP_TRX, OP_TRY, OP_LD, OP_ST, OP_PSH, OP_POP,
         OP_BRZ, OP_BRN, OP_BRC, OP_BRV, OP_BRA,
         OP_CMP, OP_AL0, OP_AL1, OP_MOV, OP_HLT: op_legal = 1'b1;
         default:                                op_legal = 1'b0;
      endcase
   end

   // Output values are computed for the state being entered and registered.
   always_comb begin
      state_d       = state;
      sp_d          = sp;
      mem_req_d     = 1'b0;
      mem_we_d      = 1'b0;
      ir_load_d     = 1'b0;
      pc_inc_d      = 1'b0;
      pc_load_d     = 1'b0;
      tr_d          = 1'b0;
      mov_d         = 1'b0;
      alu_en_d      = 1'b0;
      flag_we_d     = 1'b0;
      acc_we_d      = 1'b0;
      reg_we_d      = '0;
      halted_d      = 1'b0;
      illegal_d     = 1'b0;
      stack_fault_d = 1'b0;
`ifdef CU_IRQ_EN
      irq_ack_d     = 1'b0;
`endif
      case (state)
         S_FETCH: begin
            if (mem_req && mem_ack) begin
               state_d   = S_IRLD;
               ir_load_d = 1'b1;
               pc_inc_d  = 1'b1;
            end else begin
               mem_req_d = 1'b1;
            end
         end
         S_IRLD: state_d = S_DECODE;
         S_DECODE: begin
            if (!op_legal || int'(ra) >= NREG) begin
               illegal_d = 1'b1;
               state_d   = S_FETCH;
               mem_req_d = 1'b1;
            end else begin
               state_d = S_EXEC;
               case (opcode)
                  OP_TRX: begin tr_d = 1'b1; reg_we_d = REG_ONE;      end
                  OP_TRY: begin tr_d = 1'b1; reg_we_d = REG_ONE << 1; end
                  OP_MOV: begin mov_d = 1'b1; reg_we_d = REG_ONE << ra; end
                  OP_CMP: begin alu_en_d = 1'b1; flag_we_d = 1'b1; end
                  OP_AL0, OP_AL1: begin
                     alu_en_d  = 1'b1;
                     flag_we_d = 1'b1;
                     if (imm == '0) acc_we_d = 1'b1;
                     else           reg_we_d = REG_ONE << ra;
                  end
                  OP_BRZ: pc_load_d = flags[0];
                  OP_BRN: pc_load_d = flags[1];
                  OP_BRC: pc_load_d = flags[2];
                  OP_BRV: pc_load_d = flags[3];
                  OP_BRA: pc_load_d = 1'b1;
                  OP_PSH: stack_fault_d = (sp == SP_FULL);
                  OP_POP: stack_fault_d = (sp == '0);
                  default: ;
               endcase
            end
         end
         S_EXEC: begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
            case (opcode)
               OP_LD:  state_d = S_MEM;
               OP_ST:  begin state_d = S_MEM; mem_we_d = 1'b1; end
               OP_PSH: begin
                  if (sp != SP_FULL) begin
                     state_d  = S_MEM;
                     mem_we_d = 1'b1;
                  end
               end
               OP_POP: begin
                  if (sp != '0) begin
                     state_d = S_MEM;
                     sp_d    = sp - SP_ONE;
                  end
               end
               OP_HLT: begin
                  state_d   = S_HALT;
                  mem_req_d = 1'b0;
                  halted_d  = 1'b1;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            if (mem_req && mem_ack) begin
               state_d   = S_FETCH;
               mem_req_d = 1'b1;
               case (opcode)
                  OP_PSH: sp_d = sp + SP_ONE;
                  OP_LD: begin
                     state_d   = S_WB;
                     mem_req_d = 1'b0;
                     reg_we_d  = REG_ONE << ra;
                  end
                  OP_POP: begin
                     state_d   = S_WB;
                     mem_req_d = 1'b0;
                     if (int'(ra_stack) < NREG)          reg_we_d  = REG_ONE << ra_stack;
                     else if (int'(ra_stack) == NREG)    acc_we_d  = 1'b1;
                     else if (int'(ra_stack) == NREG+1)  pc_load_d = 1'b1;
                     else                                illegal_d = 1'b1;
                  end
                  default: ;
               endcase
            end else begin
               mem_req_d = 1'b1;
               mem_we_d  = mem_we;
            end
         end
         S_WB: begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
         end
         S_HALT: begin
            halted_d = 1'b1;
`ifdef CU_IRQ_EN
            if (irq) begin
               state_d   = S_IRQ;
               halted_d  = 1'b0;
               irq_ack_d = 1'b1;
               pc_load_d = 1'b1;
            end
`endif
         end
`ifdef CU_IRQ_EN
         S_IRQ: begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
         end
`endif
         default: begin
            state_d   = S_FETCH;
            mem_req_d = 1'b1;
         end
      endcase
`ifdef CU_IRQ_EN
      // Interrupts are taken only on entry to FETCH, never while a fetch is outstanding
      if (irq && state_d == S_FETCH && state != S_FETCH && state != S_IRQ) begin
         state_d   = S_IRQ;
         mem_req_d = 1'b0;
         mem_we_d  = 1'b0;
         irq_ack_d = 1'b1;
         pc_load_d = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_FETCH;
         sp          <= '0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         ir_load     <= 1'b0;
         pc_inc      <= 1'b0;
         pc_load     <= 1'b0;
         tr          <= 1'b0;
         mov         <= 1'b0;
         alu_en      <= 1'b0;
         flag_we     <= 1'b0;
         acc_we      <= 1'b0;
         reg_we      <= '0;
         halted      <= 1'b0;
         illegal     <= 1'b0;
         stack_fault <= 1'b0;
`ifdef CU_IRQ_EN
         irq_ack     <= 1'b0;
`endif
      end else begin
         state       <= state_d;
         sp          <= sp_d;
         mem_req     <= mem_req_d;
         mem_we      <= mem_we_d;
         ir_load     <= ir_load_d;
         pc_inc      <= pc_inc_d;
         pc_load     <= pc_load_d;
         tr          <= tr_d;
         mov         <= mov_d;
         alu_en      <= alu_en_d;
         flag_we     <= flag_we_d;
         acc_we      <= acc_we_d;
         reg_we      <= reg_we_d;
         halted      <= halted_d;
         illegal     <= illegal_d;
         stack_fault <= stack_fault_d;
`ifdef CU_IRQ_EN
         irq_ack     <= irq_ack_d;
`endif
      end
   end

endmodule

// File: tb/tb_cu_multicycle.sv
// tb/tb_cu_multicycle.sv - scoreboard testbench for cu_multicycle (default build, CU_IRQ_EN undefined)
module tb_cu_multicycle;
   localparam int OPW = 6, IMMW = 9, NREG = 2, STACK_DEPTH = 8;
   localparam int RAW = $clog2(NREG), RSW = $clog2(NREG+2), SPW = $clog2(STACK_DEPTH+1);

   localparam logic [5:0] TRX = 6'b000000, TRY = 6'b000001, LD = 6'b000010, ST = 6'b000011;
   localparam logic [5:0] PSH = 6'b000100, POP = 6'b000101, BRZ = 6'b000110, BRN = 6'b000111;
   localparam logic [5:0] BRC = 6'b001000, BRV = 6'b001001, BRA = 6'b001010, CMP = 6'b010100;
   localparam logic [5:0] AL0 = 6'b010101, AL1 = 6'b010110, MOV = 6'b010111, HLT = 6'b111111;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic [OPW-1:0]  opcode = '0;
   logic [RAW-1:0]  ra = '0;
   logic [RSW-1:0]  ra_stack = '0;
   logic [IMMW-1:0] imm = '0;
   logic [3:0]      flags = '0;
   logic            mem_ack = 1'b0;
   logic            mem_req, mem_we, ir_load, pc_inc, pc_load, tr, mov, alu_en, flag_we, acc_we;
   logic [NREG-1:0] reg_we;
   logic [SPW-1:0]  sp;
   logic            halted, illegal, stack_fault;
   logic [9:0]      obs;

   int n_checks = 0;
   int n_errors = 0;
   logic [9:0] exp_q[$];
   bit ok;

   cu_multicycle #(.OPW(OPW), .IMMW(IMMW), .NREG(NREG), .STACK_DEPTH(STACK_DEPTH)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .ra(ra), .ra_stack(ra_stack), .imm(imm),
      .flags(flags), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load), .tr(tr), .mov(mov),
      .alu_en(alu_en), .flag_we(flag_we), .acc_we(acc_we), .reg_we(reg_we), .sp(sp),
      .halted(halted), .illegal(illegal), .stack_fault(stack_fault)
   );

   always #5 clk = ~clk;

   assign obs = {pc_load, tr, mov, alu_en, flag_we, acc_we, reg_we, illegal, stack_fault};

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [9:0] w(input logic pc, input logic t, input logic m, input logic a,
                                    input logic f, input logic ac, input logic [1:0] rw,
                                    input logic il, input logic sf);
      return {pc, t, m, a, f, ac, rw, il, sf};
   endfunction

   // Every non-idle strobe cycle must match the next expected event
   always @(negedge clk) begin
      if (rst && obs != 10'd0) begin
         if (exp_q.size() == 0) check("sb_unexpected", 32'(obs), 32'd0);
         else                   check("sb_strobe", 32'(obs), 32'(exp_q.pop_front()));
      end
   end

   task automatic wait_req(output bit got);
      got = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (mem_req) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   task automatic run_instr(input logic [5:0] op, input int ra_i, input int ras_i, input int imm_i,
                            input logic [3:0] fl, input int fdel, input bit has_mem, input bit exp_we,
                            input int mdel, input logic [9:0] e_exec, input logic [9:0] e_wb);
      bit got;
      if (e_exec != 10'd0) exp_q.push_back(e_exec);
      if (e_wb != 10'd0)   exp_q.push_back(e_wb);
      wait_req(got);
      check("fetch_req", 32'(got), 32'd1);
      check("fetch_we", 32'(mem_we), 32'd0);
      repeat (fdel) @(negedge clk);
      opcode   = op;
      ra       = RAW'(ra_i);
      ra_stack = RSW'(ras_i);
      imm      = IMMW'(imm_i);
      flags    = fl;
      mem_ack  = 1'b1;
      @(negedge clk);
      mem_ack  = 1'b0;
      check("ir_load", 32'(ir_load), 32'd1);
      check("pc_inc", 32'(pc_inc), 32'd1);
      check("irld_req", 32'(mem_req), 32'd0);
      if (has_mem) begin
         wait_req(got);
         check("mem_req", 32'(got), 32'd1);
         check("mem_we", 32'(mem_we), 32'(exp_we));
         for (int i = 0; i < mdel; i++) begin
            @(negedge clk);
            check("mem_hold", 32'(mem_req), 32'd1);
         end
         mem_ack = 1'b1;
         @(negedge clk);
         mem_ack = 1'b0;
         if (op == LD || op == POP) check("mem_drop", 32'(mem_req), 32'd0);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("rst_sp", 32'(sp), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_req", 32'(mem_req), 32'd0);
      check("rst_strobes", 32'(obs), 32'd0);
      rst = 1'b1;

      // first cycle with mem_req is cycle 0; ack in cycle 2
      run_instr(TRX, 0, 0, 0, 4'b0000, 2, 0, 0, 0, w(0,1,0,0,0,0,2'b01,0,0), 10'd0);
      repeat (2) @(negedge clk);
      check("trx_c5_tr", 32'(tr), 32'd1);
      check("trx_c5_reg_we", 32'(reg_we), 32'd1);
      @(negedge clk);
      check("trx_c6_fetch", 32'(mem_req), 32'd1);

      run_instr(TRY, 0, 0, 0, 4'b0000, 0, 0, 0, 0, w(0,1,0,0,0,0,2'b10,0,0), 10'd0);
      run_instr(AL0, 0, 0, 0, 4'b0000, 1, 0, 0, 0, w(0,0,0,1,1,1,2'b00,0,0), 10'd0);
      run_instr(AL0, 1, 0, 5, 4'b0000, 0, 0, 0, 0, w(0,0,0,1,1,0,2'b10,0,0), 10'd0);
      run_instr(AL1, 0, 0, 3, 4'b0000, 0, 0, 0, 0, w(0,0,0,1,1,0,2'b01,0,0), 10'd0);
      run_instr(CMP, 1, 0, 0, 4'b0000, 0, 0, 0, 0, w(0,0,0,1,1,0,2'b00,0,0), 10'd0);
      run_instr(MOV, 1, 0, 0, 4'b0000, 0, 0, 0, 0, w(0,0,1,0,0,0,2'b10,0,0), 10'd0);
      run_instr(BRZ, 0, 0, 0, 4'b0001, 0, 0, 0, 0, w(1,0,0,0,0,0,2'b00,0,0), 10'd0);
      run_instr(BRZ, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 10'd0, 10'd0);
      run_instr(BRA, 0, 0, 0, 4'b0000, 0, 0, 0, 0, w(1,0,0,0,0,0,2'b00,0,0), 10'd0);
      run_instr(BRN, 0, 0, 0, 4'b0010, 0, 0, 0, 0, w(1,0,0,0,0,0,2'b00,0,0), 10'd0);
      run_instr(BRC, 0, 0, 0, 4'b0100, 0, 0, 0, 0, w(1,0,0,0,0,0,2'b00,0,0), 10'd0);
      run_instr(BRV, 0, 0, 0, 4'b0111, 0, 0, 0, 0, 10'd0, 10'd0);
      run_instr(BRV, 0, 0, 0, 4'b1000, 0, 0, 0, 0, w(1,0,0,0,0,0,2'b00,0,0), 10'd0);
      run_instr(6'b110000, 0, 0, 0, 4'b1111, 0, 0, 0, 0, w(0,0,0,0,0,0,2'b00,1,0), 10'd0);
      run_instr(LD, 1, 0, 0, 4'b0000, 0, 1, 0, 3, 10'd0, w(0,0,0,0,0,0,2'b10,0,0));
      run_instr(ST, 0, 0, 0, 4'b0000, 1, 1, 1, 1, 10'd0, 10'd0);

      for (int i = 0; i < STACK_DEPTH; i++) begin
         run_instr(PSH, 0, 0, 0, 4'b0000, 0, 1, 1, i % 2, 10'd0, 10'd0);
         check("sp_psh", 32'(sp), 32'(i + 1));
      end
      run_instr(PSH, 0, 0, 0, 4'b0000, 0, 0, 0, 0, w(0,0,0,0,0,0,2'b00,0,1), 10'd0);
      repeat (3) @(negedge clk);
      check("psh_full_fetch", 32'(mem_req), 32'd1);
      check("psh_full_we", 32'(mem_we), 32'd0);
      check("psh_full_sp", 32'(sp), 32'd8);

      for (int i = 0; i < STACK_DEPTH; i++) begin
         int ras;
         logic [9:0] e;
         ras = (i == 0) ? 0 : (i == 1) ? 1 : (i == STACK_DEPTH - 1) ? 3 : 2;
         e = (ras == 0) ? w(0,0,0,0,0,0,2'b01,0,0) :
             (ras == 1) ? w(0,0,0,0,0,0,2'b10,0,0) :
             (ras == 2) ? w(0,0,0,0,0,1,2'b00,0,0) :
                          w(1,0,0,0,0,0,2'b00,0,0);
         run_instr(POP, 0, ras, 0, 4'b0000, 0, 1, 0, 0, 10'd0, e);
         check("sp_pop", 32'(sp), 32'(STACK_DEPTH - 1 - i));
      end
      run_instr(POP, 0, 0, 0, 4'b0000, 0, 0, 0, 0, w(0,0,0,0,0,0,2'b00,0,1), 10'd0);
      repeat (3) @(negedge clk);
      check("pop_empty_fetch", 32'(mem_req), 32'd1);
      check("pop_empty_sp", 32'(sp), 32'd0);

      run_instr(HLT, 0, 0, 0, 4'b1111, 0, 0, 0, 0, 10'd0, 10'd0);
      repeat (3) @(negedge clk);
      check("halt_set", 32'(halted), 32'd1);
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      repeat (4) @(negedge clk);
      check("halt_hold", 32'(halted), 32'd1);
      check("halt_noreq", 32'(mem_req), 32'd0);

      rst = 1'b0;
      @(negedge clk);
      check("rst_unhalt", 32'(halted), 32'd0);
      rst = 1'b1;
      run_instr(PSH, 0, 0, 0, 4'b0000, 0, 1, 1, 0, 10'd0, 10'd0);
      check("sp_one", 32'(sp), 32'd1);
      run_instr(PSH, 0, 0, 0, 4'b0000, 0, 0, 0, 0, 10'd0, 10'd0);
      wait_req(ok);
      check("mid_mem_req", 32'(ok), 32'd1);
      check("mid_mem_we", 32'(mem_we), 32'd1);
      #3 rst = 1'b0;
      #1;
      check("async_req", 32'(mem_req), 32'd0);
      check("async_we", 32'(mem_we), 32'd0);
      check("async_sp", 32'(sp), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("post_rst_sp", 32'(sp), 32'd0);
      check("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
